instruction_store: RTL and testbench

- Parametrised byte-addressed, little-endian instruction memory. Successor to the fixed 16-bit fetch memory.
- Adds four things:
  - a post-reset hardware clear sequence;
  - a streaming program-load port with valid/ready handshake;
  - a registered fetch port with request/valid and configurable fetch width;
  - an out-of-range fault flag.
- Sits between the boot loader / debug interface (load side) and the CPU fetch stage (fetch side).

---
 rtl/instruction_store_pkg.sv | 22 ++
 rtl/instruction_store_array.sv | 38 +++
 rtl/instruction_store.sv | 168 ++++++++++++++++
 tb/tb_instruction_store.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_store_pkg.sv
// Shared types and elaboration helpers for the instruction store.
package instruction_store_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Only power-of-two fetch widths up to a 32-bit instruction are supported.
  function automatic bit fetch_bytes_legal(input int n);
    return (n == 1) || (n == 2) || (n == 4);
  endfunction

  // Width of a byte index into a DEPTH-byte array (at least one bit).
  function automatic int mem_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instruction_store_array.sv
// Byte-wide storage with one synchronous write port and FETCH_BYTES
// combinational read taps at raddr+k; taps that fall past the end read 0.
module instruction_store_array
  import instruction_store_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int FETCH_BYTES = 2,
  localparam int MEM_AW     = mem_addr_w(DEPTH)
) (
  input  logic                          CLK,
  input  logic                          we,
  input  logic [MEM_AW-1:0]             waddr,
  input  logic [BYTE_W-1:0]             wdata,
  input  logic [ADDR_W-1:0]             raddr,
  output logic [BYTE_W*FETCH_BYTES-1:0] rdata
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Single write port; the contents are not reset (the top clears them).
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < FETCH_BYTES; gi++) begin : g_tap
    logic [ADDR_W:0] tap_addr;
    // One extra bit so a tap near the top of the address space cannot wrap.
    assign tap_addr = {1'b0, raddr} + (ADDR_W+1)'(gi);
    assign rdata[gi*BYTE_W +: BYTE_W] =
      (tap_addr < DEPTH_EXT) ? mem[tap_addr[MEM_AW-1:0]] : '0;
  end

endmodule

// File: rtl/instruction_store.sv
// Instruction memory top: post-reset clear, streaming program load and a
// registered, little-endian fetch port with out-of-range fault reporting.
module instruction_store
  import instruction_store_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int FETCH_BYTES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          fetch_req,
  input  logic [ADDR_W-1:0]             fetch_addr,
  output logic                          fetch_ready,
  output logic                          fetch_valid,
  output logic [BYTE_W*FETCH_BYTES-1:0] fetch_data,
  output logic                          fetch_fault,
  input  logic                          load_start,
  input  logic [ADDR_W-1:0]             load_base,
  input  logic [ADDR_W-1:0]             load_len,
  input  logic                          load_valid,
  input  logic [BYTE_W-1:0]             load_data,
  output logic                          load_ready,
  output logic                          load_done,
  output logic                          load_err,
  output logic                          busy
);

  localparam int MEM_AW  = mem_addr_w(DEPTH);
  localparam int INSN_W  = BYTE_W * FETCH_BYTES;
  localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   FETCH_SPAN = (ADDR_W+1)'(FETCH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  if (!fetch_bytes_legal(FETCH_BYTES)) begin : g_bad_fetch_bytes
    $error("instruction_store: FETCH_BYTES must be 1, 2 or 4");
  end
  if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_W)) begin : g_bad_depth
    $error("instruction_store: DEPTH must be in 1 .. 2**ADDR_W");
  end

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wptr_q, wptr_d;          // clear pointer or load pointer
  logic [ADDR_W-1:0]  remaining_q, remaining_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               fetch_fault_q, fetch_fault_d;
  logic [INSN_W-1:0]  fetch_data_q, fetch_data_d;
  logic               load_done_q, load_done_d;
  logic               load_err_q, load_err_d;

  logic               mem_we;
  logic [BYTE_W-1:0]  mem_wdata;
  logic [INSN_W-1:0]  tap_data;
  logic               fetch_oob;
  logic               load_oob;

  // Range checks use one extra bit so base+len never wraps to a small value.
  assign fetch_oob = ({1'b0, fetch_addr} + FETCH_SPAN) > DEPTH_EXT;
  assign load_oob  = ({1'b0, load_base} + {1'b0, load_len}) > DEPTH_EXT;

  instruction_store_array #(
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .FETCH_BYTES (FETCH_BYTES)
  ) u_array (
    .CLK   (CLK),
    .we    (mem_we),
    .waddr (wptr_q[MEM_AW-1:0]),
    .wdata (mem_wdata),
    .raddr (fetch_addr),
    .rdata (tap_data)
  );

  // Next-state and next-output logic for the CLEAR / IDLE / LOAD controller.
  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    remaining_d   = remaining_q;
    fetch_valid_d = 1'b0;
    fetch_fault_d = fetch_fault_q;
    fetch_data_d  = fetch_data_q;
    load_done_d   = 1'b0;
    load_err_d    = 1'b0;
    mem_we        = 1'b0;
    mem_wdata     = '0;

    unique case (state_q)
      ST_CLEAR: begin
        mem_we = 1'b1;
        if (wptr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          wptr_d  = '0;
        end else begin
          wptr_d = wptr_q + ONE;
        end
      end

      ST_IDLE: begin
        if (fetch_req) begin
          fetch_valid_d = 1'b1;
          fetch_fault_d = fetch_oob;
          fetch_data_d  = fetch_oob ? '0 : tap_data;
        end
        // A load arriving with a fetch is still accepted; it starts next cycle.
        if (load_start) begin
          if (load_oob) begin
            load_err_d = 1'b1;
          end else if (load_len == '0) begin
            load_done_d = 1'b1;
          end else begin
            wptr_d      = load_base;
            remaining_d = load_len;
            state_d     = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (load_valid) begin
          mem_we      = 1'b1;
          mem_wdata   = load_data;
          wptr_d      = wptr_q + ONE;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // State and registered outputs; reset restarts the clear sweep from 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_CLEAR;
      wptr_q        <= '0;
      remaining_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      fetch_data_q  <= '0;
      load_done_q   <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      remaining_q   <= remaining_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fetch_data_q  <= fetch_data_d;
      load_done_q   <= load_done_d;
      load_err_q    <= load_err_d;
    end
  end

  assign fetch_ready = (state_q == ST_IDLE);
  assign load_ready  = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign fetch_valid = fetch_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fetch_data  = fetch_data_q;
  assign load_done   = load_done_q;
  assign load_err    = load_err_q;

endmodule

// File: tb/tb_instruction_store.sv
// Scoreboard bench for instruction_store: a 2-byte-fetch build is checked
// through queues; a 4-byte-fetch build shares its inputs and is spot-checked.
module tb_instruction_store;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic [ADDR_W-1:0] load_len = '0;
  logic              load_valid = 1'b0;
  logic [7:0]        load_data = '0;

  logic        fetch_ready, fetch_valid, fetch_fault, load_ready, load_done, load_err, busy;
  logic [15:0] fetch_data;
  logic        fetch_ready_w, fetch_valid_w, fetch_fault_w, load_ready_w, load_done_w, load_err_w, busy_w;
  logic [31:0] fetch_data_w;

  instruction_store #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FETCH_BYTES(2)) dut (
    .CLK(CLK), .RST(RST),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  instruction_store #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .FETCH_BYTES(4)) dut_w (
    .CLK(CLK), .RST(RST),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready_w),
    .fetch_valid(fetch_valid_w), .fetch_data(fetch_data_w), .fetch_fault(fetch_fault_w),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready_w),
    .load_done(load_done_w), .load_err(load_err_w), .busy(busy_w)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [15:0] data; logic fault; int cyc; } fetch_rec_t;
  typedef struct { logic is_err; int cyc; } load_rec_t;

  fetch_rec_t exp_fetch_q[$];
  fetch_rec_t obs_fetch_q[$];
  load_rec_t  exp_load_q[$];
  load_rec_t  obs_load_q[$];

  logic [7:0] model_mem [DEPTH];
  logic [7:0] beat_buf [8];

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor: record every response the 2-byte build produces.
  always @(negedge CLK) begin
    if (fetch_valid === 1'b1) obs_fetch_q.push_back('{fetch_data, fetch_fault, cyc});
    if (load_done === 1'b1)   obs_load_q.push_back('{1'b0, cyc});
    if (load_err === 1'b1)    obs_load_q.push_back('{1'b1, cyc});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(input int addr, input int nb);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < nb; k++)
      if (addr + k < DEPTH) w[8*k +: 8] = model_mem[addr + k];
    return w;
  endfunction

  // Drive a fetch request this cycle and predict the 2-byte response.
  task automatic push_fetch(input int addr);
    fetch_rec_t e;
    logic [31:0] w;
    fetch_req  = 1'b1;
    fetch_addr = ADDR_W'(addr);
    w       = model_word(addr, 2);
    e.fault = (addr + 2 > DEPTH);
    e.data  = e.fault ? 16'h0000 : w[15:0];
    e.cyc   = cyc + 1;
    exp_fetch_q.push_back(e);
  endtask

  // Start a session and stream nbeats bytes from beat_buf with random gaps.
  task automatic drive_load(input int base, input int len, input int nbeats);
    load_start = 1'b1;
    load_base  = ADDR_W'(base);
    load_len   = ADDR_W'(len);
    if (base + len > DEPTH)  exp_load_q.push_back('{1'b1, cyc + 1});
    else if (len == 0)       exp_load_q.push_back('{1'b0, cyc + 1});
    @(negedge CLK);
    load_start = 1'b0;
    if (base + len > DEPTH || len == 0) return;
    for (int i = 0; i < nbeats; i++) begin
      load_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      for (int t = 0; t < 8 && load_ready !== 1'b1; t++) @(negedge CLK);
      load_valid = 1'b1;
      load_data  = beat_buf[i];
      model_mem[base + i] = beat_buf[i];
      if (i == len - 1) exp_load_q.push_back('{1'b0, cyc + 1});
      @(negedge CLK);
      load_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (busy !== 1'b1 || busy_w !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy: got %b/%b, expected 1", busy, busy_w);
    end
    n_cmp++;
    if ({fetch_ready, load_ready} !== 2'b00) begin
      n_bad++; $display("FAIL reset_ready: got fetch_ready=%b load_ready=%b, expected 0/0", fetch_ready, load_ready);
    end
    n_cmp++;
    if ({fetch_valid, fetch_fault, load_done, load_err} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_pulses: got %b, expected 0000", {fetch_valid, fetch_fault, load_done, load_err});
    end
    n_cmp++;
    if (fetch_data !== 16'h0000 || fetch_data_w !== 32'h0) begin
      n_bad++; $display("FAIL reset_data: got %h/%h, expected 0", fetch_data, fetch_data_w);
    end
    $display("reset: outputs checked in reset");
  endtask

  // Release reset, count busy cycles of the clear sweep, then fetch address 0.
  task automatic test_clear(input string tag);
    int cnt;
    fetch_rec_t e, o;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    RST = 1'b1;
    cnt = 0;
    for (int i = 0; i < 400 && busy === 1'b1; i++) begin
      cnt++;
      @(negedge CLK);
    end
    n_cmp++;
    if (cnt !== DEPTH) begin
      n_bad++; $display("FAIL %s_busy_cycles: got %0d, expected %0d", tag, cnt, DEPTH);
    end
    n_cmp++;
    if (fetch_ready !== 1'b1 || fetch_ready_w !== 1'b1) begin
      n_bad++; $display("FAIL %s_fetch_ready: got %b/%b, expected 1", tag, fetch_ready, fetch_ready_w);
    end
    $display("%s: busy for %0d cycles", tag, cnt);
    push_fetch(0);
    @(negedge CLK);
    fetch_req = 1'b0;
    repeat (2) @(negedge CLK);
    while (exp_fetch_q.size() > 0) begin
      e = exp_fetch_q.pop_front();
      n_cmp++;
      if (obs_fetch_q.size() == 0) begin
        n_bad++; $display("FAIL %s_fetch: no response, expected data=%h fault=%b", tag, e.data, e.fault);
      end else begin
        o = obs_fetch_q.pop_front();
        if (o.data !== e.data || o.fault !== e.fault || o.cyc !== e.cyc) begin
          n_bad++; $display("FAIL %s_fetch: got data=%h fault=%b cyc=%0d, expected data=%h fault=%b cyc=%0d",
                            tag, o.data, o.fault, o.cyc, e.data, e.fault, e.cyc);
        end
        $display("%s: fetch data=%h fault=%b", tag, o.data, o.fault);
      end
    end
  endtask

  task automatic test_load();
    fetch_rec_t e, o;
    load_rec_t  le, lo;
    beat_buf = '{8'h2F, 8'h01, 8'h2E, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    drive_load(0, 4, 4);
    n_cmp++;
    if (fetch_ready !== 1'b1) begin
      n_bad++; $display("FAIL load_back_to_idle: got fetch_ready=%b, expected 1", fetch_ready);
    end
    push_fetch(3);          // issued the cycle after the final write
    @(negedge CLK);
    push_fetch(0);
    @(negedge CLK);
    push_fetch(1);
    @(negedge CLK);
    fetch_req = 1'b0;
    repeat (2) @(negedge CLK);
    while (exp_load_q.size() > 0) begin
      le = exp_load_q.pop_front();
      n_cmp++;
      if (obs_load_q.size() == 0) begin
        n_bad++; $display("FAIL load_event: no event observed, expected err=%b cyc=%0d", le.is_err, le.cyc);
      end else begin
        lo = obs_load_q.pop_front();
        if (lo.is_err !== le.is_err || lo.cyc !== le.cyc) begin
          n_bad++; $display("FAIL load_event: got err=%b cyc=%0d, expected err=%b cyc=%0d", lo.is_err, lo.cyc, le.is_err, le.cyc);
        end
        $display("load: event err=%b at cycle %0d", lo.is_err, lo.cyc);
      end
    end
    while (exp_fetch_q.size() > 0) begin
      e = exp_fetch_q.pop_front();
      n_cmp++;
      if (obs_fetch_q.size() == 0) begin
        n_bad++; $display("FAIL load_fetch: no response, expected data=%h", e.data);
      end else begin
        o = obs_fetch_q.pop_front();
        if (o.data !== e.data || o.fault !== e.fault || o.cyc !== e.cyc) begin
          n_bad++; $display("FAIL load_fetch: got data=%h fault=%b cyc=%0d, expected data=%h fault=%b cyc=%0d",
                            o.data, o.fault, o.cyc, e.data, e.fault, e.cyc);
        end
        $display("load: fetch data=%h fault=%b", o.data, o.fault);
      end
    end
  endtask

  // While loading: port flags, dropped fetch, ignored load_start.
  task automatic test_load_port_state();
    fetch_rec_t e, o;
    load_rec_t  le, lo;
    load_start = 1'b1; load_base = 16'h0020; load_len = 16'd2;
    @(negedge CLK);
    load_start = 1'b0;
    n_cmp++;
    if ({load_ready, fetch_ready, busy} !== 3'b101) begin
      n_bad++; $display("FAIL load_state_flags: got ready/fetch_ready/busy=%b, expected 101", {load_ready, fetch_ready, busy});
    end
    fetch_req = 1'b1; fetch_addr = 16'h0000;                         // dropped
    load_start = 1'b1; load_base = 16'h0000; load_len = 16'h0000;    // ignored
    load_valid = 1'b1; load_data = 8'hA5; model_mem[8'h20] = 8'hA5;
    @(negedge CLK);
    fetch_req = 1'b0; load_start = 1'b0;
    load_data = 8'h5A; model_mem[8'h21] = 8'h5A;
    exp_load_q.push_back('{1'b0, cyc + 1});
    @(negedge CLK);
    load_valid = 1'b0;
    push_fetch(16'h20);
    @(negedge CLK);
    fetch_req = 1'b0;
    repeat (2) @(negedge CLK);
    le = exp_load_q.pop_front();
    n_cmp++;
    if (obs_load_q.size() == 0) begin
      n_bad++; $display("FAIL load_state_done: no event observed, expected cyc=%0d", le.cyc);
    end else begin
      lo = obs_load_q.pop_front();
      if (lo.is_err !== 1'b0 || lo.cyc !== le.cyc) begin
        n_bad++; $display("FAIL load_state_done: got err=%b cyc=%0d, expected err=0 cyc=%0d", lo.is_err, lo.cyc, le.cyc);
      end
    end
    n_cmp++;
    if (obs_load_q.size() != 0) begin
      n_bad++; $display("FAIL load_state_extra_events: got %0d, expected 0", obs_load_q.size());
      obs_load_q.delete();
    end
    e = exp_fetch_q.pop_front();
    n_cmp++;
    if (obs_fetch_q.size() != 1) begin
      n_bad++; $display("FAIL load_state_fetch_count: got %0d responses, expected 1", obs_fetch_q.size());
    end
    if (obs_fetch_q.size() > 0) begin
      o = obs_fetch_q.pop_back();
      n_cmp++;
      if (o.data !== e.data || o.fault !== e.fault) begin
        n_bad++; $display("FAIL load_state_fetch: got data=%h fault=%b, expected data=%h fault=%b", o.data, o.fault, e.data, e.fault);
      end
      $display("load_state: fetch 0x20 data=%h", o.data);
    end
    obs_fetch_q.delete();
  endtask

  task automatic test_fault();
    fetch_rec_t e, o;
    load_rec_t  le, lo;
    beat_buf[0] = 8'h77;
    drive_load(255, 1, 1);        // exactly reaches DEPTH: legal
    push_fetch(16'hFFFF);
    @(negedge CLK);
    push_fetch(255);
    @(negedge CLK);
    push_fetch(254);
    @(negedge CLK);
    fetch_req = 1'b0;
    repeat (2) @(negedge CLK);
    le = exp_load_q.pop_front();
    n_cmp++;
    if (obs_load_q.size() == 0) begin
      n_bad++; $display("FAIL fault_load255: no event observed, expected done");
    end else begin
      lo = obs_load_q.pop_front();
      if (lo.is_err !== le.is_err || lo.cyc !== le.cyc) begin
        n_bad++; $display("FAIL fault_load255: got err=%b cyc=%0d, expected err=%b cyc=%0d", lo.is_err, lo.cyc, le.is_err, le.cyc);
      end
    end
    while (exp_fetch_q.size() > 0) begin
      e = exp_fetch_q.pop_front();
      n_cmp++;
      if (obs_fetch_q.size() == 0) begin
        n_bad++; $display("FAIL fault_fetch: no response, expected data=%h fault=%b", e.data, e.fault);
      end else begin
        o = obs_fetch_q.pop_front();
        if (o.data !== e.data || o.fault !== e.fault || o.cyc !== e.cyc) begin
          n_bad++; $display("FAIL fault_fetch: got data=%h fault=%b cyc=%0d, expected data=%h fault=%b cyc=%0d",
                            o.data, o.fault, o.cyc, e.data, e.fault, e.cyc);
        end
        $display("fault: fetch data=%h fault=%b", o.data, o.fault);
      end
    end
    n_cmp++;
    if (fetch_valid !== 1'b0 || fetch_data !== 16'h7700 || fetch_fault !== 1'b0) begin
      n_bad++; $display("FAIL fault_hold: got valid=%b data=%h fault=%b, expected 0/7700/0", fetch_valid, fetch_data, fetch_fault);
    end
  endtask

  task automatic test_load_reject();
    fetch_rec_t e, o;
    load_rec_t  le, lo;
    load_valid = 1'b1; load_data = 8'hFF;      // stray data must not be written
    drive_load(250, 10, 0);
    @(negedge CLK);
    load_valid = 1'b0;
    n_cmp++;
    if ({fetch_ready, load_ready, busy} !== 3'b100) begin
      n_bad++; $display("FAIL reject_state: got fetch_ready/load_ready/busy=%b, expected 100", {fetch_ready, load_ready, busy});
    end
    drive_load(5, 0, 0);
    push_fetch(250);
    @(negedge CLK);
    fetch_req = 1'b0;
    repeat (2) @(negedge CLK);
    while (exp_load_q.size() > 0) begin
      le = exp_load_q.pop_front();
      n_cmp++;
      if (obs_load_q.size() == 0) begin
        n_bad++; $display("FAIL reject_event: no event observed, expected err=%b", le.is_err);
      end else begin
        lo = obs_load_q.pop_front();
        if (lo.is_err !== le.is_err || lo.cyc !== le.cyc) begin
          n_bad++; $display("FAIL reject_event: got err=%b cyc=%0d, expected err=%b cyc=%0d", lo.is_err, lo.cyc, le.is_err, le.cyc);
        end
        $display("reject: event err=%b", lo.is_err);
      end
    end
    n_cmp++;
    if (obs_load_q.size() != 0) begin
      n_bad++; $display("FAIL reject_extra_events: got %0d, expected 0", obs_load_q.size());
      obs_load_q.delete();
    end
    e = exp_fetch_q.pop_front();
    n_cmp++;
    if (obs_fetch_q.size() == 0) begin
      n_bad++; $display("FAIL reject_mem: no response, expected data=%h", e.data);
    end else begin
      o = obs_fetch_q.pop_front();
      if (o.data !== e.data || o.fault !== e.fault) begin
        n_bad++; $display("FAIL reject_mem: got data=%h fault=%b, expected data=%h fault=%b", o.data, o.fault, e.data, e.fault);
      end
    end
  endtask

  task automatic test_reset_abort();
    fetch_rec_t e, o;
    beat_buf = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00, 8'h00};
    drive_load(16'h40, 6, 2);
    RST = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if ({busy, load_ready} !== 2'b10) begin
      n_bad++; $display("FAIL abort_in_reset: got busy/load_ready=%b, expected 10", {busy, load_ready});
    end
    test_clear("reclear");
    push_fetch(16'h40);
    @(negedge CLK);
    fetch_req = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (obs_load_q.size() != 0 || exp_load_q.size() != 0) begin
      n_bad++; $display("FAIL abort_no_done: got %0d events, expected 0", obs_load_q.size());
      obs_load_q.delete(); exp_load_q.delete();
    end
    e = exp_fetch_q.pop_front();
    n_cmp++;
    if (obs_fetch_q.size() == 0) begin
      n_bad++; $display("FAIL abort_mem: no response, expected data=%h", e.data);
    end else begin
      o = obs_fetch_q.pop_front();
      if (o.data !== 16'h0000 || o.fault !== 1'b0) begin
        n_bad++; $display("FAIL abort_mem: got data=%h fault=%b, expected 0000/0", o.data, o.fault);
      end
      $display("abort: fetch 0x40 data=%h", o.data);
    end
  endtask

  task automatic test_back_to_back();
    fetch_rec_t e, o;
    load_rec_t  lo;
    int first_cyc;
    beat_buf = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    drive_load(8, 4, 4);
    push_fetch(8);
    @(negedge CLK);
    n_cmp++;
    if (fetch_valid_w !== 1'b1 || fetch_data_w !== 32'h44332211 || fetch_fault_w !== 1'b0) begin
      n_bad++; $display("FAIL b2b_wide_8: got valid=%b data=%h fault=%b, expected 1/44332211/0", fetch_valid_w, fetch_data_w, fetch_fault_w);
    end
    push_fetch(9);
    @(negedge CLK);
    fetch_req = 1'b0;
    n_cmp++;
    if (fetch_valid_w !== 1'b1 || fetch_data_w !== 32'h00443322) begin
      n_bad++; $display("FAIL b2b_wide_9: got valid=%b data=%h, expected 1/00443322", fetch_valid_w, fetch_data_w);
    end
    $display("b2b: wide fetch 9 data=%h", fetch_data_w);
    @(negedge CLK);
    n_cmp++;
    if (fetch_valid_w !== 1'b0) begin
      n_bad++; $display("FAIL b2b_wide_idle: got valid=%b, expected 0", fetch_valid_w);
    end
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (obs_load_q.size() != 1) begin
      n_bad++; $display("FAIL b2b_load_done: got %0d events, expected 1", obs_load_q.size());
    end
    if (obs_load_q.size() > 0) lo = obs_load_q.pop_front();
    obs_load_q.delete(); exp_load_q.delete();
    first_cyc = -1;
    while (exp_fetch_q.size() > 0) begin
      e = exp_fetch_q.pop_front();
      n_cmp++;
      if (obs_fetch_q.size() == 0) begin
        n_bad++; $display("FAIL b2b_fetch: no response, expected data=%h", e.data);
      end else begin
        o = obs_fetch_q.pop_front();
        if (o.data !== e.data || o.fault !== e.fault || o.cyc !== e.cyc) begin
          n_bad++; $display("FAIL b2b_fetch: got data=%h fault=%b cyc=%0d, expected data=%h fault=%b cyc=%0d",
                            o.data, o.fault, o.cyc, e.data, e.fault, e.cyc);
        end
        if (first_cyc >= 0) begin
          n_cmp++;
          if (o.cyc !== first_cyc + 1) begin
            n_bad++; $display("FAIL b2b_consecutive: got cycle %0d, expected %0d", o.cyc, first_cyc + 1);
          end
        end
        first_cyc = o.cyc;
        $display("b2b: fetch data=%h cyc=%0d", o.data, o.cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear("clear");
    test_load();
    test_load_port_state();
    test_fault();
    test_load_reject();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
